// File: rtl/ctrl_pkg.sv
// Shared opcode/funct constants, control bundle and forwarding encodings for the
// MIPS pipeline control unit.
package ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [2:0] OP_ITYPE_HI = 3'b001;

  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_MFHI = 6'h10;
  localparam logic [5:0] FN_MFLO = 6'h12;
  // mult/multu/div/divu share funct[5:2]; funct[1:0] selects the op
  localparam logic [3:0] FN_MULDIV_HI = 4'b0110;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_RTYPE = 2'b10,
    ALU_ITYPE = 2'b11
  } aluop_e;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_e;

  typedef struct packed {
    logic   signext;
    aluop_e aluop;
    logic   alusrc;
    logic   memread;
    logic   memwrite;
    logic   memtoreg;
    logic   regwrite;
    logic   regdst;
    logic   branch;
    logic   branchne;
    logic   jump;
    logic   jumpr;
    logic   link;
  } ctrl_t;

endpackage

// File: rtl/ctrl_pipe_decode.sv
// Combinational opcode/funct decode into the control bundle plus register-use flags.
// CTRL_MULDIV_EN adds mult/div and mfhi/mflo classification outputs.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  output ctrl_t      ctrl_o,
  output logic       uses_rs_o,
  output logic       uses_rt_o
`ifdef CTRL_MULDIV_EN
  ,
  output logic       muldiv_o,
  output logic       mfhilo_o
`endif
);

  always_comb begin
    ctrl_o    = '0;
    uses_rs_o = 1'b0;
    uses_rt_o = 1'b0;
`ifdef CTRL_MULDIV_EN
    muldiv_o  = 1'b0;
    mfhilo_o  = 1'b0;
`endif
    case (opcode_i)
      OP_RTYPE: begin
        uses_rs_o = 1'b1;
        uses_rt_o = 1'b1;
        if (funct_i == FN_JR) begin
          ctrl_o.jump  = 1'b1;
          ctrl_o.jumpr = 1'b1;
        end else begin
          ctrl_o.aluop    = ALU_RTYPE;
          ctrl_o.regdst   = 1'b1;
          ctrl_o.regwrite = 1'b1;
`ifdef CTRL_MULDIV_EN
          // mult/div write HI/LO, never the register file
          if (funct_i[5:2] == FN_MULDIV_HI) begin
            muldiv_o        = 1'b1;
            ctrl_o.regdst   = 1'b0;
            ctrl_o.regwrite = 1'b0;
          end
          mfhilo_o = (funct_i == FN_MFHI) || (funct_i == FN_MFLO);
`endif
        end
      end
      OP_LW: begin
        ctrl_o.signext  = 1'b1;
        ctrl_o.alusrc   = 1'b1;
        ctrl_o.memread  = 1'b1;
        ctrl_o.memtoreg = 1'b1;
        ctrl_o.regwrite = 1'b1;
        uses_rs_o       = 1'b1;
      end
      OP_SW: begin
        ctrl_o.signext  = 1'b1;
        ctrl_o.alusrc   = 1'b1;
        ctrl_o.memwrite = 1'b1;
        uses_rs_o       = 1'b1;
        uses_rt_o       = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        ctrl_o.signext  = 1'b1;
        ctrl_o.aluop    = ALU_SUB;
        ctrl_o.branch   = 1'b1;
        ctrl_o.branchne = (opcode_i == OP_BNE);
        uses_rs_o       = 1'b1;
        uses_rt_o       = 1'b1;
      end
      OP_J: ctrl_o.jump = 1'b1;
      OP_JAL: begin
        ctrl_o.jump     = 1'b1;
        ctrl_o.link     = 1'b1;
        ctrl_o.regwrite = 1'b1;
      end
      default: begin
        if (opcode_i[5:3] == OP_ITYPE_HI) begin
          ctrl_o.signext  = ~opcode_i[2];
          ctrl_o.aluop    = ALU_ITYPE;
          ctrl_o.alusrc   = 1'b1;
          ctrl_o.regwrite = 1'b1;
          uses_rs_o       = 1'b1;
        end
      end
    endcase
  end

endmodule

// File: rtl/ctrl_pipe.sv
// Pipelined control for the 5-stage MIPS core: ID decode, load-use stall, bubbles,
// EX forwarding selects. CTRL_MULDIV_EN enables mult/div issue and HI/LO interlock.
module ctrl_pipe
  import ctrl_pkg::*;
#(
  parameter int RW         = 5,
  parameter int LINK_REG   = 31,
  parameter int MULDIV_LAT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          id_valid,
  input  logic [5:0]    id_opcode,
  input  logic [5:0]    id_funct,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic [RW-1:0] id_rd,
  input  logic          flush_ex,
  output logic          stall,
  output logic          id_signext,
  output logic          id_jump,
  output logic          id_jumpr,
  output logic          ex_valid,
  output logic [1:0]    ex_aluop,
  output logic          ex_alusrc,
  output logic          ex_branch,
  output logic          ex_branchne,
  output logic          ex_link,
  output logic [1:0]    ex_fwd_a,
  output logic [1:0]    ex_fwd_b,
  output logic          mem_memread,
  output logic          mem_memwrite,
  output logic          wb_regwrite,
  output logic          wb_memtoreg,
  output logic [RW-1:0] wb_wreg,
  output logic          ex_muldiv_start,
  output logic [1:0]    ex_muldiv_op
);

  typedef struct packed {
    logic          valid;
    aluop_e        aluop;
    logic          alusrc, branch, branchne, link;
    logic          memread, memwrite, memtoreg, regwrite;
    logic [RW-1:0] wreg, rs, rt;
  } ex_t;

  typedef struct packed {
    logic          memread, memwrite, memtoreg, regwrite;
    logic [RW-1:0] wreg;
  } mem_t;

  typedef struct packed {
    logic          memtoreg, regwrite;
    logic [RW-1:0] wreg;
  } wb_t;

  ctrl_t         dec;
  logic          uses_rs, uses_rt;
  logic [RW-1:0] id_wreg;
  logic          lu_hz, md_hz, bubble;
  ex_t           ex_d, ex_q;
  mem_t          mem_q;
  wb_t           wb_q;

`ifdef CTRL_MULDIV_EN
  localparam int BW = $clog2(MULDIV_LAT + 1);
  logic          id_muldiv, id_mfhilo;
  logic [BW-1:0] busy_d, busy_q;
  logic          md_start_q;
  logic [1:0]    md_op_q;
`endif

  ctrl_decode u_decode (
    .opcode_i  (id_opcode),
    .funct_i   (id_funct),
    .ctrl_o    (dec),
    .uses_rs_o (uses_rs),
    .uses_rt_o (uses_rt)
`ifdef CTRL_MULDIV_EN
    ,
    .muldiv_o  (id_muldiv),
    .mfhilo_o  (id_mfhilo)
`endif
  );

  always_comb begin
    id_wreg = '0;
    if (dec.regwrite)
      id_wreg = dec.regdst ? id_rd : (dec.link ? RW'(LINK_REG) : id_rt);
  end

  assign lu_hz = id_valid & ex_q.valid & ex_q.memread & (ex_q.wreg != '0) &
                 ((uses_rs & (ex_q.wreg == id_rs)) | (uses_rt & (ex_q.wreg == id_rt)));
  // flush kills the ID instruction anyway, so it overrides any stall
  assign stall  = (lu_hz | md_hz) & ~flush_ex;
  assign bubble = flush_ex | stall | ~id_valid;

  assign id_signext = dec.signext;
  assign id_jump    = id_valid & dec.jump;
  assign id_jumpr   = dec.jumpr;

  always_comb begin
    ex_d = '0;
    if (!bubble) begin
      ex_d.valid    = 1'b1;
      ex_d.aluop    = dec.aluop;
      ex_d.alusrc   = dec.alusrc;
      ex_d.branch   = dec.branch;
      ex_d.branchne = dec.branchne;
      ex_d.link     = dec.link;
      ex_d.memread  = dec.memread;
      ex_d.memwrite = dec.memwrite;
      ex_d.memtoreg = dec.memtoreg;
      ex_d.regwrite = dec.regwrite;
      ex_d.wreg     = id_wreg;
      ex_d.rs       = id_rs;
      ex_d.rt       = id_rt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= '{ex_q.memread, ex_q.memwrite, ex_q.memtoreg, ex_q.regwrite, ex_q.wreg};
      wb_q  <= '{mem_q.memtoreg, mem_q.regwrite, mem_q.wreg};
    end
  end

  function automatic logic [1:0] fwd_sel(input logic [RW-1:0] src);
    if (mem_q.regwrite && mem_q.wreg != '0 && mem_q.wreg == src) return FWD_MEM;
    if (wb_q.regwrite && wb_q.wreg != '0 && wb_q.wreg == src)    return FWD_WB;
    return FWD_RF;
  endfunction

  assign ex_fwd_a     = fwd_sel(ex_q.rs);
  assign ex_fwd_b     = fwd_sel(ex_q.rt);
  assign ex_valid     = ex_q.valid;
  assign ex_aluop     = ex_q.aluop;
  assign ex_alusrc    = ex_q.alusrc;
  assign ex_branch    = ex_q.branch;
  assign ex_branchne  = ex_q.branchne;
  assign ex_link      = ex_q.link;
  assign mem_memread  = mem_q.memread;
  assign mem_memwrite = mem_q.memwrite;
  assign wb_regwrite  = wb_q.regwrite;
  assign wb_memtoreg  = wb_q.memtoreg;
  assign wb_wreg      = wb_q.wreg;

`ifdef CTRL_MULDIV_EN
  assign md_hz = id_valid & (busy_q != '0) & (id_muldiv | id_mfhilo);

  // counter loads as the op enters EX; flushes never cancel an issued op
  always_comb begin
    busy_d = busy_q;
    if (!bubble && id_muldiv) busy_d = BW'(MULDIV_LAT);
    else if (busy_q != '0)    busy_d = busy_q - BW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q     <= '0;
      md_start_q <= 1'b0;
      md_op_q    <= 2'b00;
    end else begin
      busy_q     <= busy_d;
      md_start_q <= ~bubble & id_muldiv;
      md_op_q    <= (~bubble & id_muldiv) ? id_funct[1:0] : 2'b00;
    end
  end

  assign ex_muldiv_start = md_start_q;
  assign ex_muldiv_op    = md_op_q;
`else
  assign md_hz           = 1'b0;
  assign ex_muldiv_start = 1'b0;
  assign ex_muldiv_op    = 2'b00;
`endif

endmodule

// File: doc/ctrl_pipe.md
Name: ctrl_pipe

Overview:
- Pipelined control unit for the 5-stage MIPS core. Decodes opcode/funct in ID and carries the control bundle through ID/EX, EX/MEM and MEM/WB.
- Detects load-use hazards and stalls IF/ID, inserts bubbles on stall/flush, and generates EX-stage forwarding selects.
- Datapath pipeline registers stay in the datapath; this block owns only control state.

Parameters:
- RW, 5, register-address width.
- LINK_REG, 31, destination register for jal.
- MULDIV_LAT, 4, mult/div busy cycles; used only with the optional feature.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- id_valid  in  1  ID holds a real instruction.
- id_opcode  in  6  instr[31:26].
- id_funct  in  6  instr[5:0].
- id_rs  in  RW  instr[25:21].
- id_rt  in  RW  instr[20:16].
- id_rd  in  RW  instr[15:11].
- flush_ex  in  1  taken branch resolved in EX; kill the ID instruction.
- stall  out  1  hold PC and IF/ID.
- id_signext  out  1  combinational; immediate extension for ID.
- id_jump  out  1  combinational, j/jal/jr, gated by id_valid.
- id_jumpr  out  1  combinational, jr.
- ex_valid  out  1  EX-stage valid.
- ex_aluop  out  2  EX-stage ALU op class.
- ex_alusrc  out  1  EX-stage ALU operand source.
- ex_branch  out  1  EX-stage branch.
- ex_branchne  out  1  EX-stage bne select.
- ex_link  out  1  EX-stage jal.
- ex_fwd_a  out  2  ALU operand A select: 00 regfile, 10 MEM, 01 WB.
- ex_fwd_b  out  2  ALU operand B select, same encoding.
- mem_memread  out  1  MEM-stage memory read.
- mem_memwrite  out  1  MEM-stage memory write.
- wb_regwrite  out  1  WB-stage register write.
- wb_memtoreg  out  1  WB-stage writeback source.
- wb_wreg  out  RW  WB-stage destination address.
- ex_muldiv_start  out  1  optional feature; tied 0 when compiled out.
- ex_muldiv_op  out  2  optional feature; tied 0 when compiled out.

Behaviour:
- Decode classes:
  - lw, sw, beq, bne, j, jal.
  - R-type: opcode 0; funct 0x08 means jr.
  - I-type ALU: opcode 001xxx; signext = ~opcode[2].
  - Every don't-care decodes to 0. Unknown opcode gives an all-zero bundle (a NOP).
- Destination register:
  - wreg = rd if regdst; LINK_REG if link; rt otherwise.
  - Forced to 0 when regwrite = 0.
- Use flags:
  - uses_rs is 1 for all classes except j/jal.
  - uses_rt is 1 for R-type, sw, beq, bne.
- Load-use hazard:
  - hz = id_valid & ex_valid & ex_memread & ex_wreg != 0 & ((uses_rs & ex_wreg == id_rs) | (uses_rt & ex_wreg == id_rt)).
  - stall = hz & ~flush_ex. It is combinational, with no added latency.
- ID/EX capture on each clock edge:
  - If flush_ex or stall or ~id_valid, capture a bubble: all controls 0, ex_valid = 0.
  - Otherwise capture the decoded bundle together with rs and rt.
- EX/MEM and MEM/WB always advance; there is no back-pressure from this block.
- Forwarding, per EX operand (rs for A, rt for B):
  - 10 when mem_regwrite & mem_wreg != 0 & mem_wreg == operand.
  - Else 01 when the same test matches on the WB stage.
  - Else 00. MEM has priority over WB.
- Simultaneous flush_ex and hazard: flush wins; stall = 0 and a bubble is inserted.
- jr with a load-use hazard on rs: stall asserts; id_jump stays asserted while stalled, and the PC logic qualifies it with ~stall.
- Reset clears every pipeline register to 0, including all valids. stall, the forwarding selects and wb_wreg are 0 in reset. Reset mid-stream discards all in-flight control.

Optional Feature:
- Macro: CTRL_MULDIV_EN.
- With the macro:
  - Decode funct 0x18/0x19/0x1a/0x1b as mult/multu/div/divu; ex_muldiv_op = funct[1:0].
  - ex_muldiv_start pulses for 1 cycle in EX.
  - A busy counter loads MULDIV_LAT and decrements each cycle.
  - mfhi (0x10) or mflo (0x12) in ID while busy != 0 raises stall with the same bubble rules as a load-use stall.
  - A second mult/div in ID while busy also stalls.
  - flush_ex kills only the ID instruction; it never cancels an EX-started op.
- Without the macro: those functs decode as plain R-type, ex_muldiv_* are tied to 0, and no counter exists.

Decomposition:
- ctrl_pkg holds:
  - opcode and funct constants;
  - the ctrl_t bundle typedef (signext, aluop, alusrc, memread, memwrite, memtoreg, regwrite, regdst, branch, branchne, jump, jumpr, link);
  - the forwarding-select encodings.
- Sub-module ctrl_decode: purely combinational opcode/funct to ctrl_t, plus the use flags. ctrl_pipe instantiates it once.

Test Plan:
- lw $8 then add $9,$8,$2 → stall = 1 for 1 cycle, then ex_valid = 0 (bubble), then add reaches EX with ex_fwd_a = 01.
- add $3,$1,$2 then sub $4,$3,$3 → no stall; sub in EX has ex_fwd_a = ex_fwd_b = 10.
- jal → id_jump = 1; in WB, wb_regwrite = 1 and wb_wreg = 31.
- Load-use hazard coinciding with flush_ex = 1 → stall = 0; next ex_valid = 0.
- Undefined opcode 0x3f, and lw writing $0 followed by a dependent use → all controls 0 and no stall.
- CTRL_MULDIV_EN, MULDIV_LAT = 4: mult then mflo → ex_muldiv_start pulses once; mflo stalls until the busy counter reaches 0; total stall is 4 cycles.
